jtag_tap_gen: RTL
=================

JTAG_TAP_GEN -- requirements
Module: jtag_tap_gen

Interface
REQ-001 SHALL have parameter IRW, default 5, instruction register width.
REQ-002 SHALL have parameter IDCODE, default 32'h00000001, device identification value.
REQ-003 SHALL have parameter NCH, default 2, number of external data-register channels.
REQ-004 SHALL have parameter CH_BASE, default 'h10, instruction code of channel 0; channel k is selected by CH_BASE+k.
REQ-005 SHALL have port tck, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port trst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port tms, input, 1 bit: mode select.
REQ-008 SHALL have port tdi, input, 1 bit: serial data in.
REQ-009 SHALL have port tdo, output, 1 bit: registered serial data out.
REQ-010 SHALL have port tdo_oe, output, 1 bit: registered tdo enable.
REQ-011 SHALL have port ir_out, output, IRW bits: current instruction.
REQ-012 SHALL have port dr_select, output, NCH bits: one-hot channel select, all zero when no channel is selected.
REQ-013 SHALL have port dr_tdo, input, NCH bits: per-channel serial return.
REQ-014 SHALL have ports capture_dr, shift_dr and update_dr, output, 1 bit each: high while the FSM is in Capture-DR, Shift-DR and Update-DR respectively.
REQ-015 SHALL have port test_logic_reset, output, 1 bit: high while the FSM is in Test-Logic-Reset.

Function
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM with standard tms transitions:
- TLR, RTI, Sel-DR, Cap-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Upd-DR.
- Sel-IR, Cap-IR, Shift-IR, Exit1-IR, Pause-IR, Exit2-IR, Upd-IR.
REQ-017 SHALL reach TLR after five consecutive tck edges with tms=1 from any state.
REQ-018 SHALL load the IR shift register with {zeros, 2'b01} in Cap-IR.
REQ-019 SHALL shift the IR shift register right in Shift-IR, with tdi entering the MSB.
REQ-020 SHALL copy the IR shift register to ir_out in Upd-IR.
REQ-021 SHALL define the BYPASS instruction as all-ones and the IDCODE instruction as 'h01.
REQ-022 SHALL treat any instruction code other than IDCODE, BYPASS or a channel code as BYPASS.
REQ-023 SHALL implement a 1-bit bypass register: captures 0 in Cap-DR, shifts tdi in Shift-DR.
REQ-024 SHALL implement a 32-bit IDCODE register: captures IDCODE in Cap-DR, shifts right in Shift-DR with tdi entering bit 31.
REQ-025 SHALL decode dr_select combinationally from ir_out only.
REQ-026 SHALL hold the channel's data register externally; the block only routes dr_tdo[k] and asserts the strobes.
REQ-027 SHALL, on each edge taken while in Shift-IR, register tdo <= IR shift LSB before the shift; tdo is therefore the pre-shift LSB, one cycle late.
REQ-028 SHALL, on each edge taken while in Shift-DR, register tdo <= the pre-shift LSB of the selected internal register, or dr_tdo[k] for a channel.
REQ-029 SHALL hold tdo in all other states.
REQ-030 SHALL register tdo_oe <= (state is Shift-IR or Shift-DR) on every edge.
REQ-031 SHALL make ir_out change only in Upd-IR, TLR or reset, so an instruction change during Shift-DR is impossible.
REQ-032 SHALL register all outputs except the FSM-decoded strobes and dr_select.

Reset
REQ-033 SHALL, when trst_n is low at a rising tck, force: state=TLR, ir_out=reset instruction, IR/bypass/IDCODE shift registers=0, tdo=0, tdo_oe=0.
REQ-034 SHALL abort any in-progress shift on reset; no Upd strobe is produced.
REQ-035 SHALL load ir_out with the reset instruction in TLR, whether TLR is entered by tms or by reset.

Configuration
REQ-036 SHALL compile the IDCODE register in when macro JTAG_TAP_GEN_IDCODE_EN is defined:
- reset instruction = 'h01.
- IDCODE instruction selects the 32-bit IDCODE register.
REQ-037 SHALL, without JTAG_TAP_GEN_IDCODE_EN:
- omit the IDCODE register.
- reset instruction = BYPASS.
- decode 'h01 as BYPASS.

Verification
REQ-038 SHALL cover: trst_n=0 for one edge -> state TLR, test_logic_reset=1, tdo_oe=0, ir_out=5'h01 (macro on) or 5'h1f (macro off).
REQ-039 SHALL cover: macro on, from RTI tms=1,0,0 then 33 Shift-DR edges -> tdo bits, LSB first, read 0x00000001, tdo_oe=1 throughout.
REQ-040 SHALL cover: shift IR=5'h1f via Shift-IR, then Upd-IR -> ir_out=5'h1f; a subsequent Shift-DR with tdi pattern 1,0,1 -> tdo 0,1,0 (delayed two edges).
REQ-041 SHALL cover: Cap-IR then Shift-IR for 5 edges -> tdo 1,0,0,0,0.
REQ-042 SHALL cover: IR=5'h11, NCH=2 -> dr_select=2'b10; dr_tdo=2'b10 in Shift-DR -> tdo=1 next edge; capture_dr/update_dr high exactly one cycle each.
REQ-043 SHALL cover: mid Shift-DR, tms=1 for five edges -> TLR, ir_out=reset instruction; trst_n low mid Shift-IR -> ir_out unchanged by the partial shift.

Source files
------------

// File: rtl/jtag_tap_gen.sv
// IEEE 1149.1 TAP controller with a bypass register and NCH external DR channels.
// Define JTAG_TAP_GEN_IDCODE_EN to build in the 32-bit IDCODE register; it is omitted by default.
module jtag_tap_gen #(
    parameter int          IRW     = 5,
    parameter logic [31:0] IDCODE  = 32'h00000001,
    parameter int          NCH     = 2,
    parameter int          CH_BASE = 'h10
) (
    input  logic           tck,
    input  logic           trst_n,
    input  logic           tms,
    input  logic           tdi,
    output logic           tdo,
    output logic           tdo_oe,
    output logic [IRW-1:0] ir_out,
    output logic [NCH-1:0] dr_select,
    input  logic [NCH-1:0] dr_tdo,
    output logic           capture_dr,
    output logic           shift_dr,
    output logic           update_dr,
    output logic           test_logic_reset,
    output logic [3:0]     tap_state_o
);

    typedef enum logic [3:0] {
        TLR        = 4'd0,
        RTI        = 4'd1,
        SEL_DR     = 4'd2,
        CAPTURE_DR = 4'd3,
        SHIFT_DR   = 4'd4,
        EXIT1_DR   = 4'd5,
        PAUSE_DR   = 4'd6,
        EXIT2_DR   = 4'd7,
        UPDATE_DR  = 4'd8,
        SEL_IR     = 4'd9,
        CAPTURE_IR = 4'd10,
        SHIFT_IR   = 4'd11,
        EXIT1_IR   = 4'd12,
        PAUSE_IR   = 4'd13,
        EXIT2_IR   = 4'd14,
        UPDATE_IR  = 4'd15
    } tap_state_e;

    localparam logic [IRW-1:0] BYPASS_IR  = '1;
    localparam logic [IRW-1:0] IR_CAPTURE = IRW'(2'b01);
`ifdef JTAG_TAP_GEN_IDCODE_EN
    localparam logic [IRW-1:0] IDCODE_IR  = IRW'(1);
    localparam logic [IRW-1:0] RST_IR     = IDCODE_IR;
`else
    localparam logic [IRW-1:0] RST_IR     = BYPASS_IR;
`endif

    tap_state_e     state_q, state_d;
    logic [IRW-1:0] ir_q;
    logic [IRW-1:0] ir_sr_q;
    logic           bypass_q;
    logic           tdo_q;
    logic           tdo_oe_q;
    logic [NCH-1:0] sel;
    logic           dr_lsb;
`ifdef JTAG_TAP_GEN_IDCODE_EN
    logic [31:0]    idcode_q;
    logic           idcode_sel;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:        state_d = tms ? TLR       : RTI;
            RTI:        state_d = tms ? SEL_DR    : RTI;
            SEL_DR:     state_d = tms ? SEL_IR    : CAPTURE_DR;
            CAPTURE_DR: state_d = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_d = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_d = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_d = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_d = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_d = tms ? SEL_DR    : RTI;
            SEL_IR:     state_d = tms ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_d = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_d = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_d = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_d = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_d = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_d = tms ? SEL_DR    : RTI;
            default:    state_d = TLR;
        endcase
    end

    // Channel decode looks at the committed instruction only, so it cannot glitch mid-shift.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ir_q == IRW'(CH_BASE + k)) sel[k] = 1'b1;
        end
    end

`ifdef JTAG_TAP_GEN_IDCODE_EN
    assign idcode_sel = (ir_q == IDCODE_IR) && !(|sel);
`endif

    always_comb begin
        if (|sel) begin
            dr_lsb = |(dr_tdo & sel);
`ifdef JTAG_TAP_GEN_IDCODE_EN
        end else if (idcode_sel) begin
            dr_lsb = idcode_q[0];
`endif
        end else begin
            dr_lsb = bypass_q;
        end
    end

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            state_q  <= TLR;
            ir_q     <= RST_IR;
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
`ifdef JTAG_TAP_GEN_IDCODE_EN
            idcode_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tdo_oe_q <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
            case (state_q)
                CAPTURE_IR: ir_sr_q <= IR_CAPTURE;
                SHIFT_IR: begin
                    tdo_q   <= ir_sr_q[0];
                    ir_sr_q <= {tdi, ir_sr_q[IRW-1:1]};
                end
                UPDATE_IR:  ir_q <= ir_sr_q;
                CAPTURE_DR: begin
                    bypass_q <= 1'b0;
`ifdef JTAG_TAP_GEN_IDCODE_EN
                    idcode_q <= IDCODE;
`endif
                end
                SHIFT_DR: begin
                    tdo_q    <= dr_lsb;
                    bypass_q <= tdi;
`ifdef JTAG_TAP_GEN_IDCODE_EN
                    idcode_q <= {tdi, idcode_q[31:1]};
`endif
                end
                default: ;
            endcase
            // Entering or sitting in TLR restores the reset instruction, same as trst_n.
            if (state_d == TLR) ir_q <= RST_IR;
        end
    end

    assign tdo              = tdo_q;
    assign tdo_oe           = tdo_oe_q;
    assign ir_out           = ir_q;
    assign dr_select        = sel;
    assign capture_dr       = (state_q == CAPTURE_DR);
    assign shift_dr         = (state_q == SHIFT_DR);
    assign update_dr        = (state_q == UPDATE_DR);
    assign test_logic_reset = (state_q == TLR);
    assign tap_state_o      = state_q;

endmodule
